// File: rtl/rtc_alarm_wb_if.sv
`default_nettype none
// ============================================================================
// Module   : rtc_alarm_wb_if
// Purpose  : Wishbone classic slave bundle for the RTC alarm scheduler.
// Revision : 1.0
// ============================================================================
interface rtc_alarm_wb_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o
    );
endinterface
`default_nettype wire

// File: rtl/rtc_alarm_wb.sv
`default_nettype none
// ============================================================================
// Module   : rtc_alarm_wb
// Purpose  : NCH countdown alarms on the 100 Hz tick, one shared decrementer.
// Revision : 1.0
// ============================================================================
module rtc_alarm_wb #(
    parameter int NCH = 4
) (
    input  wire logic     wb_clk_i,
    input  wire logic     wb_rst_i,
    rtc_alarm_wb_if.slave wb,
    input  wire logic     tick_i,
    output logic          int_o
);
    localparam int                 c_IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(NCH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } t_state;

    t_state               r_state, w_state_nx;
    logic [c_IDX_W-1:0]   r_idx, w_idx_nx;
    logic                 r_tick_pend, w_tpend_nx;
    logic                 w_ovr_set;

    logic [31:0]          r_reload [NCH];
    logic [31:0]          r_count  [NCH];
    logic [NCH-1:0]       r_en, r_per, r_pend, r_irqen;
    logic                 r_overrun, r_ack, r_int;
    logic [31:0]          r_dat;

    logic                 w_acc, w_wr, w_busy, w_ch_ok;
    logic [5:0]           w_off;
    logic [3:0]           w_ch;
    logic [NCH-1:0]       w_wr_rel, w_wr_cnt, w_wr_cfg, w_scan, w_fire, w_w1c;
    logic [31:0]          w_rdata;
    logic                 w_unused;

    assign w_acc    = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
    assign w_wr     = w_acc & wb.wb_we_i;
    assign w_off    = wb.wb_adr_i[7:2];
    assign w_ch     = w_off[5:2] - 4'd1;
    assign w_ch_ok  = (w_off[5:2] != 4'd0) && (w_ch < 4'(NCH));
    assign w_busy   = (r_state == S_SCAN) | r_tick_pend;
    assign w_w1c    = (w_wr && w_off == 6'd0) ? wb.wb_dat_i[NCH-1:0] : '0;
    assign w_unused = ^{wb.wb_sel_i, wb.wb_adr_i[31:8], wb.wb_adr_i[1:0]};

    // Per-channel write strobes and scan results; a SW write to the scanned
    // channel suppresses the whole scan update for that channel, pend included.
    always_comb begin
        w_wr_rel = '0;
        w_wr_cnt = '0;
        w_wr_cfg = '0;
        w_scan   = '0;
        w_fire   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_wr && w_ch_ok && (w_ch == 4'(i))) begin
                w_wr_rel[i] = (w_off[1:0] == 2'd0);
                w_wr_cnt[i] = (w_off[1:0] == 2'd1);
                w_wr_cfg[i] = (w_off[1:0] == 2'd2);
            end
            w_scan[i] = (r_state == S_SCAN) && (r_idx == c_IDX_W'(i)) && r_en[i]
                        && !(w_wr_rel[i] || w_wr_cnt[i] || w_wr_cfg[i]);
            w_fire[i] = w_scan[i] && (r_count[i] <= 32'd1);
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_off)
            6'd0:    w_rdata = 32'(r_pend);
            6'd1:    w_rdata = 32'(r_irqen);
            6'd2:    w_rdata = {30'd0, r_overrun, w_busy};
            default: begin
                for (int i = 0; i < NCH; i++) begin
                    if (w_ch_ok && (w_ch == 4'(i))) begin
                        case (w_off[1:0])
                            2'd0:    w_rdata = r_reload[i];
                            2'd1:    w_rdata = r_count[i];
                            2'd2:    w_rdata = {30'd0, r_per[i], r_en[i]};
                            default: w_rdata = '0;
                        endcase
                    end
                end
            end
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_tpend_nx = r_tick_pend;
        w_ovr_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (tick_i || r_tick_pend) begin
                    w_state_nx = S_SCAN;
                    w_idx_nx   = '0;
                    w_tpend_nx = 1'b0;
                    w_ovr_set  = tick_i && r_tick_pend;
                end
            end
            S_SCAN: begin
                if (tick_i) begin
                    if (r_tick_pend) w_ovr_set  = 1'b1;
                    else             w_tpend_nx = 1'b1;
                end
                if (r_idx == c_LAST) begin
                    w_idx_nx = '0;
                    // A queued tick restarts the walk without passing through IDLE
                    if (r_tick_pend) w_tpend_nx = 1'b0;
                    else             w_state_nx = S_IDLE;
                end else begin
                    w_idx_nx = r_idx + c_IDX_W'(1);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_tick_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_idx       <= w_idx_nx;
            r_tick_pend <= w_tpend_nx;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack     <= 1'b0;
            r_dat     <= '0;
            r_int     <= 1'b0;
            r_pend    <= '0;
            r_irqen   <= '0;
            r_overrun <= 1'b0;
            r_en      <= '0;
            r_per     <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_reload[i] <= '0;
                r_count[i]  <= '0;
            end
        end else begin
            r_ack     <= w_acc;
            if (w_acc) r_dat <= w_rdata;
            r_int     <= |(r_pend & r_irqen);
            r_pend    <= (r_pend & ~w_w1c) | w_fire;
            if (w_wr && w_off == 6'd1) r_irqen <= wb.wb_dat_i[NCH-1:0];
            r_overrun <= (r_overrun & ~(w_wr && w_off == 6'd2 && wb.wb_dat_i[1])) | w_ovr_set;
            for (int i = 0; i < NCH; i++) begin
                if (w_wr_rel[i]) r_reload[i] <= wb.wb_dat_i;
                if (w_wr_cnt[i]) begin
                    r_count[i] <= wb.wb_dat_i;
                end else if (w_scan[i]) begin
                    if (!w_fire[i])                                r_count[i] <= r_count[i] - 32'd1;
                    else if (r_per[i] && r_reload[i] != 32'd0)     r_count[i] <= r_reload[i];
                    else                                           r_count[i] <= '0;
                end
                if (w_wr_cfg[i]) begin
                    r_en[i]  <= wb.wb_dat_i[0];
                    r_per[i] <= wb.wb_dat_i[1];
                end else if (w_fire[i] && !(r_per[i] && r_reload[i] != 32'd0)) begin
                    r_en[i]  <= 1'b0;
                end
            end
        end
    end

    assign wb.wb_ack_o = r_ack;
    assign wb.wb_dat_o = r_dat;
    assign int_o       = r_int;

endmodule
`default_nettype wire

// File: tb/tb_rtc_alarm_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtc_alarm_wb
// Purpose  : Randomised and directed checks of rtc_alarm_wb against a timeline model.
// Revision : 1.0
// ============================================================================
module tb_rtc_alarm_wb;
    localparam int NCH = 4;
    localparam logic [31:0] A_PEND = 32'h00, A_IRQEN = 32'h04, A_STAT = 32'h08;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i;
    logic tick_i;
    logic int_o;

    rtc_alarm_wb_if bus();

    rtc_alarm_wb #(.NCH(NCH)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .wb       (bus.slave),
        .tick_i   (tick_i),
        .int_o    (int_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_pass = 0;
    int n_chk  = 0;

    // Reference state: register contents plus the edge at which the current walk began
    int             m_edge, m_ss;
    bit             m_q, m_ovr, m_ack, m_int, m_rd_valid;
    logic [31:0]    m_rd;
    logic [31:0]    m_rel [NCH];
    logic [31:0]    m_cnt [NCH];
    bit             m_en  [NCH];
    bit             m_per [NCH];
    logic [NCH-1:0] m_pend, m_irqen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] a_rel(int ch); return 32'(16 + 16 * ch); endfunction
    function automatic logic [31:0] a_cnt(int ch); return 32'(20 + 16 * ch); endfunction
    function automatic logic [31:0] a_cfg(int ch); return 32'(24 + 16 * ch); endfunction

    task automatic model_reset();
        m_ss = -100; m_q = 0; m_ovr = 0; m_ack = 0; m_int = 0; m_rd_valid = 0;
        m_pend = '0; m_irqen = '0;
        for (int i = 0; i < NCH; i++) begin
            m_rel[i] = '0; m_cnt[i] = '0; m_en[i] = 0; m_per[i] = 0;
        end
    endtask

    function automatic logic [31:0] model_read(int off, bit busy);
        int ch, rg;
        if (off == 0) return 32'(m_pend);
        if (off == 1) return 32'(m_irqen);
        if (off == 2) return {30'd0, m_ovr, busy};
        if (off < 4) return '0;
        ch = off / 4 - 1;
        rg = off % 4;
        if (ch >= NCH || rg == 3) return '0;
        if (rg == 0) return m_rel[ch];
        if (rg == 1) return m_cnt[ch];
        return {30'd0, m_per[ch], m_en[ch]};
    endfunction

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_edge();
        int e, ss0, off, wch, wrg, ch;
        bit q0, act, acc, wr, hit;
        logic [NCH-1:0] fire;
        logic [31:0] d;
        m_edge = m_edge + 1;
        e   = m_edge;
        ss0 = m_ss;
        q0  = m_q;
        act = (e > ss0) && (e <= ss0 + NCH);
        acc = bus.wb_cyc_i && bus.wb_stb_i && !m_ack;
        wr  = acc && bus.wb_we_i;
        d   = bus.wb_dat_i;
        off = int'(bus.wb_adr_i[7:2]);
        wch = (off >= 4) ? off / 4 - 1 : -1;
        wrg = off % 4;
        m_rd_valid = acc && !bus.wb_we_i;
        if (m_rd_valid) m_rd = model_read(off, act || q0);
        m_int = |(m_pend & m_irqen);
        m_ack = acc;
        fire  = '0;
        if (act) begin
            ch  = e - ss0 - 1;
            hit = wr && (wch == ch) && (wrg != 3);
            if (m_en[ch] && !hit) begin
                if (m_cnt[ch] > 1) m_cnt[ch] = m_cnt[ch] - 1;
                else begin
                    fire[ch] = 1'b1;
                    if (m_per[ch] && m_rel[ch] != 0) m_cnt[ch] = m_rel[ch];
                    else begin m_cnt[ch] = 0; m_en[ch] = 0; end
                end
            end
        end
        if (wr && off == 0) m_pend = m_pend & ~d[NCH-1:0];
        m_pend = m_pend | fire;
        if (wr && off == 1) m_irqen = d[NCH-1:0];
        if (wr && off == 2 && d[1]) m_ovr = 0;
        if (wr && wch >= 0 && wch < NCH) begin
            case (wrg)
                0: m_rel[wch] = d;
                1: m_cnt[wch] = d;
                2: begin m_en[wch] = d[0]; m_per[wch] = d[1]; end
                default: ;
            endcase
        end
        if (act) begin
            if (tick_i) begin
                if (q0) m_ovr = 1;
                else    m_q = 1;
            end
            if (e == ss0 + NCH && q0) begin m_ss = e; m_q = 0; end
        end else if (tick_i || q0) begin
            if (tick_i && q0) m_ovr = 1;
            m_ss = e;
            m_q  = 0;
        end
    endtask

    task automatic clk_step();
        model_edge();
        @(posedge wb_clk_i);
        #1;
        tick_i = 1'b0;
        check("ack", 32'(bus.wb_ack_o), 32'(m_ack));
        check("int", 32'(int_o), 32'(m_int));
        if (m_rd_valid) check("rdata", bus.wb_dat_o, m_rd);
    endtask

    task automatic idle(int n);
        repeat (n) clk_step();
    endtask

    task automatic wb_access(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                             output logic [31:0] rd);
        int n;
        n = 0;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
        bus.wb_adr_i = adr;  bus.wb_dat_i = dat;  bus.wb_sel_i = 4'hf;
        do begin
            clk_step();
            n++;
        end while (!bus.wb_ack_o && n < 4);
        if (!bus.wb_ack_o) check("ack_timeout", 32'd0, 32'd1);
        rd = bus.wb_dat_o;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] rd;
        wb_access(1'b1, adr, dat, rd);
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] rd);
        wb_access(1'b0, adr, 32'd0, rd);
    endtask

    task automatic pulse_tick();
        tick_i = 1'b1;
        clk_step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int r, ch, rg;
        wb_rst_i = 1'b1; tick_i = 1'b0;
        bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_we_i = 1'b0;
        bus.wb_sel_i = '0; bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0;
        m_edge = 0;
        model_reset();
        repeat (2) @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        check("rst_ack", 32'(bus.wb_ack_o), 32'd0);
        check("rst_dat", bus.wb_dat_o, 32'd0);
        check("rst_int", 32'(int_o), 32'd0);
        wb_read(A_STAT, rd);
        check("rst_status", rd, 32'd0);

        // One-shot countdown of 3
        wb_write(a_rel(0), 0); wb_write(a_cnt(0), 3); wb_write(a_cfg(0), 1); wb_write(A_IRQEN, 1);
        for (int t = 1; t <= 3; t++) begin
            pulse_tick();
            idle(NCH + 2);
            wb_read(A_PEND, rd);
            check("oneshot_pend", rd, (t == 3) ? 32'd1 : 32'd0);
        end
        wb_read(a_cfg(0), rd);
        check("oneshot_cfg", rd, 32'd0);
        wb_write(A_PEND, 1);

        // Periodic reload of 2 on channel 1
        wb_write(a_rel(1), 2); wb_write(a_cnt(1), 2); wb_write(a_cfg(1), 3); wb_write(A_IRQEN, 2);
        for (int t = 1; t <= 6; t++) begin
            pulse_tick();
            idle(NCH + 2);
            wb_read(A_PEND, rd);
            check("periodic_pend", rd, (t % 2 == 0) ? 32'd2 : 32'd0);
            if (t % 2 == 0) begin
                wb_read(a_cnt(1), rd);
                check("periodic_count", rd, 32'd2);
                wb_write(A_PEND, 2);
            end
        end

        // All channels fire on one tick
        for (int i = 0; i < NCH; i++) begin
            wb_write(a_cnt(i), 1);
            wb_write(a_cfg(i), 1);
        end
        wb_write(A_IRQEN, 32'hf);
        pulse_tick();
        wb_read(A_STAT, rd);
        check("scan_busy", rd & 32'd1, 32'd1);
        idle(NCH + 2);
        wb_read(A_STAT, rd);
        check("scan_idle", rd, 32'd0);
        wb_read(A_PEND, rd);
        check("scan_pend", rd, 32'hf);
        wb_write(A_PEND, 32'hf);

        // Tick queued mid-scan, then an overrun
        pulse_tick(); clk_step(); pulse_tick();
        idle(3 * NCH);
        wb_read(A_STAT, rd);
        check("queued_no_ovr", rd, 32'd0);
        pulse_tick(); clk_step(); pulse_tick(); pulse_tick();
        idle(3 * NCH);
        wb_read(A_STAT, rd);
        check("overrun_set", rd, 32'd2);
        wb_write(A_STAT, 2);
        wb_read(A_STAT, rd);
        check("overrun_clr", rd, 32'd0);

        // Same-edge collisions: W1C vs fire, COUNT write vs scan
        wb_write(a_cnt(0), 1); wb_write(a_cfg(0), 1);
        wb_write(a_cnt(2), 5); wb_write(a_cfg(2), 1);
        pulse_tick();
        wb_write(A_PEND, 1);
        idle(NCH + 2);
        wb_read(A_PEND, rd);
        check("w1c_vs_fire", rd & 32'd1, 32'd1);
        pulse_tick(); clk_step(); clk_step();
        wb_write(a_cnt(2), 50);
        idle(NCH + 2);
        wb_read(a_cnt(2), rd);
        check("sw_wins_count", rd, 32'd50);

        // Asynchronous reset mid-scan
        wb_write(A_IRQEN, 32'hf);
        wb_write(a_rel(3), 32'h1234);
        wb_read(a_rel(3), rd);
        check("pre_rst_int", 32'(int_o), 32'd1);
        pulse_tick(); clk_step();
        wb_rst_i = 1'b1;
        #1;
        check("arst_ack", 32'(bus.wb_ack_o), 32'd0);
        check("arst_dat", bus.wb_dat_o, 32'd0);
        check("arst_int", 32'(int_o), 32'd0);
        model_reset();
        #2;
        wb_rst_i = 1'b0;
        wb_read(a_cnt(2), rd);  check("arst_count", rd, 32'd0);
        wb_read(a_cfg(2), rd);  check("arst_cfg", rd, 32'd0);
        wb_read(A_PEND, rd);    check("arst_pend", rd, 32'd0);
        wb_write(a_cnt(0), 1); wb_write(a_cfg(0), 1); wb_write(A_IRQEN, 1);
        pulse_tick();
        idle(NCH + 2);
        wb_read(A_PEND, rd);
        check("post_rst_fire", rd, 32'd1);

        // Randomised traffic with ticks landing anywhere
        for (int it = 0; it < 400; it++) begin
            tick_i = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 9);
            if (r < 4) begin
                ch = $urandom_range(0, NCH);
                rg = $urandom_range(0, 3);
                case (rg)
                    0: wb_write(a_rel(ch), $urandom_range(0, 3));
                    1: wb_write(a_cnt(ch), $urandom_range(0, 4));
                    2: wb_write(a_cfg(ch), $urandom_range(0, 3));
                    default: wb_write(a_cfg(ch) + 4, $urandom);
                endcase
            end else if (r == 4) begin
                wb_write(A_PEND, $urandom);
            end else if (r == 5) begin
                wb_write($urandom_range(0, 1) ? A_IRQEN : A_STAT, $urandom);
            end else if (r < 8) begin
                rd = $urandom;
                wb_read({rd[31:8], 6'($urandom_range(0, 63)), rd[1:0]}, rd);
            end else begin
                idle($urandom_range(1, 3));
            end
        end
        idle(3 * NCH);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
